// File: rtl/simd_vec_lane_packer.sv
// Scalar (a,b) element stream to lane-parallel A/B beats for the SIMD MAC, with start/last framing.
// Optional sticky err_o for dropped/clamped commands when SIMD_PACKER_ERR_EN is defined.
module simd_vec_lane_packer #(
  parameter  int NUM_LANES    = 4,
  parameter  int ELEM_W       = 16,
  parameter  int MAX_NUM_ELEM = 64,
  localparam int LEN_W        = $clog2(MAX_NUM_ELEM + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [LEN_W-1:0]            cmd_len_i,
  input  logic                        elem_valid_i,
  output logic                        elem_ready_o,
  input  logic [ELEM_W-1:0]           elem_a_i,
  input  logic [ELEM_W-1:0]           elem_b_i,
  output logic                        valid_o,
  output logic                        start_o,
  output logic                        last_o,
  output logic [NUM_LANES*ELEM_W-1:0] a_o,
  output logic [NUM_LANES*ELEM_W-1:0] b_o
`ifdef SIMD_PACKER_ERR_EN
  ,
  output logic                        err_o
`endif
);

  localparam int LIDX_W = $clog2(NUM_LANES);
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(NUM_LANES - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_NUM_ELEM);

  typedef enum logic {IDLE, PACK} state_t;

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    remaining_reg;
  logic [LIDX_W-1:0]   lane_idx_reg;
  logic                first_beat_reg;
  logic [ELEM_W-1:0]   a_stage_reg [NUM_LANES];
  logic [ELEM_W-1:0]   b_stage_reg [NUM_LANES];

  logic                cmd_fire, elem_fire, len_zero, len_over;
  logic                last_elem, lane_full, beat;
  logic [LEN_W-1:0]    len_eff;
  logic [NUM_LANES*ELEM_W-1:0] beat_a, beat_b;

  assign cmd_fire  = cmd_valid_i & cmd_ready_o;
  assign elem_fire = elem_valid_i & elem_ready_o;
  assign len_zero  = (cmd_len_i == '0);
  assign len_over  = (cmd_len_i > MAX_LEN);
  assign len_eff   = len_over ? MAX_LEN : cmd_len_i;
  assign last_elem = (remaining_reg == LEN_W'(1));
  assign lane_full = (lane_idx_reg == LAST_LANE);
  assign beat      = elem_fire & (last_elem | lane_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_fire && !len_zero) state_next = PACK;
      PACK:    if (beat && last_elem)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o  = 1'b0;
    elem_ready_o = 1'b0;
    case (state_reg)
      IDLE:    cmd_ready_o  = 1'b1;
      PACK:    elem_ready_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_reg  <= '0;
      lane_idx_reg   <= '0;
      first_beat_reg <= 1'b0;
    end else if (cmd_fire && !len_zero) begin
      remaining_reg  <= len_eff;
      lane_idx_reg   <= '0;
      first_beat_reg <= 1'b1;
    end else if (elem_fire) begin
      remaining_reg <= remaining_reg - LEN_W'(1);
      if (beat) begin
        lane_idx_reg   <= '0;
        first_beat_reg <= 1'b0;
      end else begin
        lane_idx_reg <= lane_idx_reg + LIDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        a_stage_reg[k] <= '0;
        b_stage_reg[k] <= '0;
      end
    end else if (beat) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        a_stage_reg[k] <= '0;
        b_stage_reg[k] <= '0;
      end
    end else if (elem_fire) begin
      a_stage_reg[lane_idx_reg] <= elem_a_i;
      b_stage_reg[lane_idx_reg] <= elem_b_i;
    end
  end

  // Completed beat: staged lanes below lane_idx, the incoming element at lane_idx, zeros above.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam logic [LIDX_W-1:0] LANE = LIDX_W'(gi);
    assign beat_a[gi*ELEM_W +: ELEM_W] = (LANE < lane_idx_reg)  ? a_stage_reg[gi] :
                                         (LANE == lane_idx_reg) ? elem_a_i : '0;
    assign beat_b[gi*ELEM_W +: ELEM_W] = (LANE < lane_idx_reg)  ? b_stage_reg[gi] :
                                         (LANE == lane_idx_reg) ? elem_b_i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      start_o <= 1'b0;
      last_o  <= 1'b0;
      a_o     <= '0;
      b_o     <= '0;
    end else begin
      valid_o <= beat;
      start_o <= beat & first_beat_reg;
      last_o  <= beat & last_elem;
      if (beat) begin
        a_o <= beat_a;
        b_o <= beat_b;
      end
    end
  end

`ifdef SIMD_PACKER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err_o <= 1'b0;
    else if (cmd_fire && (len_zero || len_over)) err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_simd_vec_lane_packer.sv
// Randomized/directed bench for simd_vec_lane_packer against a per-vector beat model.
// Define SIMD_PACKER_ERR_EN here as well as in the RTL to exercise err_o.
module tb_simd_vec_lane_packer;
  localparam int N    = 4;
  localparam int W    = 16;
  localparam int MAXE = 64;
  localparam int LW   = $clog2(MAXE + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready_o;
  logic [LW-1:0] cmd_len = '0;
  logic          elem_valid = 1'b0;
  logic          elem_ready_o;
  logic [W-1:0]  elem_a = '0;
  logic [W-1:0]  elem_b = '0;
  logic          valid_o, start_o, last_o;
  logic [N*W-1:0] a_o, b_o;
`ifdef SIMD_PACKER_ERR_EN
  logic          err_o;
`endif

  simd_vec_lane_packer #(.NUM_LANES(N), .ELEM_W(W), .MAX_NUM_ELEM(MAXE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len),
    .elem_valid_i(elem_valid), .elem_ready_o(elem_ready_o),
    .elem_a_i(elem_a), .elem_b_i(elem_b),
    .valid_o(valid_o), .start_o(start_o), .last_o(last_o),
    .a_o(a_o), .b_o(b_o)
`ifdef SIMD_PACKER_ERR_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] pa [0:127];
  logic [W-1:0] pb [0:127];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat j of a vector of eff elements: element j*N+k in lane k, zero past the end.
  function automatic logic [N*W-1:0] model_beat(input int j, input int eff, input bit sel_b);
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = j * N + k;
      if (idx < eff) r[k*W +: W] = sel_b ? pb[idx] : pa[idx];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 128; i++) begin
      pa[i] = W'($urandom);
      pb[i] = W'($urandom);
    end
  endtask

  // mode: 0 = element every cycle, 1 = valid toggles 1,0,1,0, 2 = random gaps
  task automatic run_vec(input int len, input int mode, input bit hold_cmd);
    int eff, sent, guard, t, j;
    bit v, rdy, exp_beat;
    eff = (len > MAXE) ? MAXE : len;
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    check("cmd_ready_idle", cmd_ready_o, 1);
    tick();
    if (!hold_cmd) cmd_valid = 1'b0;
    check("valid_after_cmd", valid_o, 0);
    if (eff == 0) begin
      cmd_valid = 1'b0;
      check("len0_stays_idle", cmd_ready_o, 1);
      check("len0_elem_ready", elem_ready_o, 0);
      tick();
      check("len0_no_beat", valid_o, 0);
      return;
    end
    sent = 0; guard = 0; t = 0;
    while (sent < eff && guard < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      t++; guard++;
      elem_valid = v;
      elem_a = pa[sent];
      elem_b = pb[sent];
      rdy = elem_ready_o;
      check("cmd_ready_in_pack", cmd_ready_o, 0);
      tick();
      if (v && rdy) sent++;
      exp_beat = v && rdy && ((sent % N == 0) || (sent == eff));
      check("valid", valid_o, exp_beat);
      if (exp_beat) begin
        j = (sent - 1) / N;
        $display("beat len=%0d j=%0d a=%h b=%h start=%0b last=%0b", len, j, a_o, b_o, start_o, last_o);
        check("beat_a", a_o, model_beat(j, eff, 1'b0));
        check("beat_b", b_o, model_beat(j, eff, 1'b1));
        check("start", start_o, (j == 0));
        check("last", last_o, (sent == eff));
      end else begin
        check("start_idle", start_o, 0);
        check("last_idle", last_o, 0);
      end
    end
    check("elem_count", sent, eff);
    elem_valid = 1'b0;
    cmd_valid  = 1'b0;
    check("back_idle_cmd_ready", cmd_ready_o, 1);
    check("back_idle_elem_ready", elem_ready_o, 0);
    tick();
    check("quiet_after_vec", valid_o, 0);
  endtask

  initial begin
    #12;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_elem_ready", elem_ready_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_start", start_o, 0);
    check("rst_last", last_o, 0);
    check("rst_a", a_o, 0);
    check("rst_b", b_o, 0);
`ifdef SIMD_PACKER_ERR_EN
    check("rst_err", err_o, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin pa[i] = W'(i + 1); pb[i] = W'(1); end
    run_vec(8, 0, 1'b0);
    fill_rand();
    for (int i = 0; i < 5; i++) pa[i] = W'(10 + i);
    run_vec(5, 0, 1'b0);
    pa[0] = W'(-3); pb[0] = W'(7);
    run_vec(1, 0, 1'b0);
    fill_rand();
    run_vec(8, 1, 1'b1);
`ifdef SIMD_PACKER_ERR_EN
    check("err_before_bad", err_o, 0);
`endif
    run_vec(0, 0, 1'b0);
`ifdef SIMD_PACKER_ERR_EN
    check("err_after_len0", err_o, 1);
`endif
    fill_rand();
    run_vec(100, 2, 1'b0);
`ifdef SIMD_PACKER_ERR_EN
    check("err_sticky", err_o, 1);
`endif

    // Reset after 6 of 8 elements: beat 0 emerges, the partial second beat never does.
    fill_rand();
    cmd_valid = 1'b1; cmd_len = LW'(8);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      elem_valid = 1'b1; elem_a = pa[i]; elem_b = pb[i];
      tick();
      check("rst_vec_valid", valid_o, (i == 3));
    end
    elem_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_cmd_ready", cmd_ready_o, 1);
    check("midrst_elem_ready", elem_ready_o, 0);
    check("midrst_a", a_o, 0);
`ifdef SIMD_PACKER_ERR_EN
    check("midrst_err", err_o, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_valid", valid_o, 0);
    check("postrst_cmd_ready", cmd_ready_o, 1);
    fill_rand();
    run_vec(4, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      fill_rand();
      run_vec(int'($urandom_range(0, 70)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
